jtdsp16_docache: RTL and testbench
==================================

Name: jtdsp16_docache

Overview:
- Sequencer for the DSP16 "do K { NI instructions }" and "redo K" loops.
- Captures loop words from program ROM on the first pass into a 15-entry instruction cache, then replays them from the cache for the remaining iterations while holding the program counter.
- Sits between ROM fetch and instruction decode, and drives the X-side instruction source select.
- Consumes the do_start/do_data pair issued by the instruction decoder.

Parameters:
- DW, 16, instruction word width
- AW, 4, cache address width; depth is 2^AW-1 = 15 entries (NI max)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- cen  in  1  instruction-slot clock enable; all state changes only on clk edges with cen=1
- do_start  in  1  one-slot pulse: do/redo decoded
- do_data  in  11  [10:7]=NI (0 = redo), [6:0]=K iteration count
- rom_dout  in  DW  word currently fetched from ROM
- inst_adv  in  1  current instruction word consumed this slot (PC would advance)
- cache_dout  out  DW  word read from cache at rd_ptr (combinational from array)
- up_xcache  out  1  decoder must take its instruction from cache_dout instead of rom_dout
- pc_hold  out  1  XAAU must not increment PC
- no_int  out  1  interrupts blocked (high while any loop is active)
- loop_busy  out  1  FILL or REPLAY state
- iter_left  out  7  iterations remaining, including the current one
- fault  out  1  sticky illegal-request flag (see Optional Feature)

Behaviour:
- Reset (rst=0 at a clk edge, regardless of cen):
  - State IDLE; all outputs 0; cache_dout = 0; stored NI = 0.
  - Cache contents are don't-care.
  - Reset mid-loop aborts immediately; a later redo then faults, since stored NI = 0.
- States: IDLE, FILL, REPLAY.
- IDLE:
  - do_start with NI>0 and K>=2: latch NI and K, wr_ptr=0, iter_left=K, go to FILL.
  - do_start with NI=0 (redo) and stored NI>0 and K>=2: rd_ptr=0, iter_left=K, go to REPLAY. The whole redo runs from cache.
  - do_start with K<2, or redo with stored NI=0: illegal; request ignored; stay in IDLE.
- FILL:
  - up_xcache=0, pc_hold=0.
  - On each cen with inst_adv=1: cache[wr_ptr] <= rom_dout; wr_ptr++.
  - On the write with wr_ptr==NI-1: iter_left--, rd_ptr=0, go to REPLAY.
  - Slots with inst_adv=0 (two-cycle instructions) write nothing.
- REPLAY:
  - up_xcache=1 and pc_hold=1, registered: asserted on the same edge the state is entered.
  - On each cen with inst_adv=1: rd_ptr++.
  - When rd_ptr==NI-1: rd_ptr=0 and iter_left--.
  - If iter_left was 1 at that point: go to IDLE. up_xcache and pc_hold deassert on that edge, so the next slot fetches the word after the loop from ROM.
- no_int = loop_busy. It also asserts in the do_start slot itself: combinational OR with a legal do_start.
- do_start while loop_busy (nested do): ignored, loop continues unaffected; counted as illegal.
- Counters are 7-bit unsigned with no wrap. K is 7 bits, so the maximum is 127 iterations.
- inst_adv and do_start in the same slot: do_start has priority in IDLE. In the other states do_start is the illegal nested case and inst_adv is processed normally.

Optional Feature:
- Macro JTDSP16_DOCACHE_FAULT_EN.
- Defined: fault sets to 1 on any illegal request (K<2, redo with empty cache, nested do). It stays set until reset.
- Undefined: fault is tied to 0; illegal requests are still ignored exactly as above.

Test Plan:
- do NI=3, K=4, ROM words 0x1111/0x2222/0x3333, inst_adv=1 every slot:
  - 3 FILL slots with up_xcache=0, then 9 REPLAY slots with cache_dout cycling 1111,2222,3333.
  - iter_left steps 4→3→2→1→0; pc_hold drops after the 12th loop word; no_int high for all 12 slots.
- Same loop with inst_adv=0 inserted on the 2nd fill slot and the 5th replay slot:
  - No extra cache writes; cache_dout is held during the stalls; total consumed loop words still 12.
- redo K=2 after the above: REPLAY immediately, 6 words from cache (1111..3333 twice), up_xcache=1 throughout, no ROM writes.
- Illegal requests, each ignored with state IDLE and fault=1 when the macro is defined (fault=0 with it undefined):
  - Redo right after reset.
  - do K=1.
  - do_start during FILL.
- rst=0 during REPLAY with iter_left=3: next edge gives IDLE, all outputs 0; a following redo K=2 is illegal.
- NI=15, K=127 boundary:
  - wr_ptr reaches 14 and then enters REPLAY.
  - rd_ptr wraps 14→0, 1890 replay slots in total.
  - Exits cleanly with iter_left=0.

Source files
------------

// File: rtl/jtdsp16_docache.sv
// -----------------------------------------------------------------------------
// jtdsp16_docache
//
// Sequencer for the DSP16 "do K { NI instructions }" and "redo K" loops.
// During the first pass (FILL) the loop body is fetched from ROM as usual and
// copied into a small instruction cache. The remaining iterations (REPLAY) are
// served from that cache while the program counter is frozen. A "redo" replays
// the last cached body K times without touching ROM at all.
//
// Optional feature: define JTDSP16_DOCACHE_FAULT_EN to get a sticky fault flag
// on illegal requests. Without it, fault is tied low. Illegal requests are
// ignored in both builds.
//
// Ports:
//   clk, rst      system clock, synchronous active-low reset
//   cen           instruction-slot enable; state only moves on clk with cen=1
//   do_start      one-slot pulse from the decoder: do/redo decoded
//   do_data       [10:7] NI (0 = redo), [6:0] K iteration count
//   rom_dout      word currently fetched from ROM
//   inst_adv      current instruction word consumed this slot
//   cache_dout    cached word at the read pointer (0 when not replaying)
//   up_xcache     decoder takes cache_dout instead of rom_dout
//   pc_hold       XAAU must not advance the PC
//   no_int        interrupts blocked while a loop is active or starting
//   loop_busy     FILL or REPLAY in progress
//   iter_left     iterations remaining, including the current one
//   fault         sticky illegal-request flag
// -----------------------------------------------------------------------------
module jtdsp16_docache #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          do_start,
  input  logic [10:0]   do_data,
  input  logic [DW-1:0] rom_dout,
  input  logic          inst_adv,
  output logic [DW-1:0] cache_dout,
  output logic          up_xcache,
  output logic          pc_hold,
  output logic          no_int,
  output logic          loop_busy,
  output logic [6:0]    iter_left,
  output logic          fault
);

  localparam int DEPTH = 2**AW - 1;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    REPLAY
  } state_t;

  state_t        state;
  logic [AW-1:0] ni;        // body length of the last accepted do
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [DW-1:0] cache [DEPTH];

  logic [AW-1:0] req_ni;
  logic [6:0]    req_k;
  logic          req_legal;
  logic          fill_last;
  logic          replay_last;

  assign req_ni = do_data[10:7];
  assign req_k  = do_data[6:0];

  // A redo (NI=0) is only meaningful once a body has been cached since reset.
  assign req_legal = (req_k >= 7'd2) && ((req_ni != '0) || (ni != '0));

  assign fill_last   = (wr_ptr == ni - AW'(1));
  assign replay_last = (rd_ptr == ni - AW'(1));

  // Interrupts must already be blocked in the slot that issues the do, before
  // the state register has had a chance to move.
  assign no_int = loop_busy | ((state == IDLE) & do_start & req_legal);

  // up_xcache is high exactly while replaying, so it also masks the
  // undefined cache contents after reset.
  assign cache_dout = up_xcache ? cache[rd_ptr] : '0;

  // NOTE: the cache array is deliberately left out of reset; its contents are
  // don't-care until written, and a resettable array would stop it mapping
  // onto plain RAM/register-file cells.
  always_ff @(posedge clk) begin
    if (cen && (state == FILL) && inst_adv) begin
      cache[wr_ptr] <= rom_dout;
    end
  end

  // NOTE: every register in a clocked block uses non-blocking assignment so
  // that all branches see the pre-edge values of state, pointers and counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ni        <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      iter_left <= '0;
      up_xcache <= 1'b0;
      pc_hold   <= 1'b0;
      loop_busy <= 1'b0;
    end else if (cen) begin
      case (state)
        IDLE: begin
          if (do_start && req_legal) begin
            iter_left <= req_k;
            loop_busy <= 1'b1;
            if (req_ni != '0) begin
              ni     <= req_ni;
              wr_ptr <= '0;
              state  <= FILL;
            end else begin
              // redo: the whole run comes from the cache
              rd_ptr    <= '0;
              up_xcache <= 1'b1;
              pc_hold   <= 1'b1;
              state     <= REPLAY;
            end
          end
        end

        FILL: begin
          if (inst_adv) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (fill_last) begin
              iter_left <= iter_left - 7'd1;
              rd_ptr    <= '0;
              up_xcache <= 1'b1;
              pc_hold   <= 1'b1;
              state     <= REPLAY;
            end
          end
        end

        REPLAY: begin
          if (inst_adv) begin
            if (replay_last) begin
              rd_ptr    <= '0;
              iter_left <= iter_left - 7'd1;
              if (iter_left == 7'd1) begin
                // Release the PC on this edge so the next slot fetches the
                // word following the loop from ROM.
                up_xcache <= 1'b0;
                pc_hold   <= 1'b0;
                loop_busy <= 1'b0;
                state     <= IDLE;
              end
            end else begin
              rd_ptr <= rd_ptr + AW'(1);
            end
          end
        end

        default: begin
          state     <= IDLE;
          up_xcache <= 1'b0;
          pc_hold   <= 1'b0;
          loop_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef JTDSP16_DOCACHE_FAULT_EN
  // Illegal: K<2, redo with nothing cached, or any do while a loop runs.
  logic fault_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fault_q <= 1'b0;
    end else if (cen && do_start && ((state != IDLE) || !req_legal)) begin
      fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_jtdsp16_docache.sv
// -----------------------------------------------------------------------------
// tb_jtdsp16_docache
//
// Self-checking bench for jtdsp16_docache. The reference model tracks a loop
// as "words consumed so far out of NI*K": the first NI words come from ROM
// (and are recorded), every later word is cache[consumed % NI], and the
// remaining iteration count is K - consumed/NI.
// -----------------------------------------------------------------------------
module tb_jtdsp16_docache;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cen = 1'b0;
  logic        do_start = 1'b0;
  logic [10:0] do_data = '0;
  logic [15:0] rom_dout = '0;
  logic        inst_adv = 1'b0;
  logic [15:0] cache_dout;
  logic        up_xcache;
  logic        pc_hold;
  logic        no_int;
  logic        loop_busy;
  logic [6:0]  iter_left;
  logic        fault;

  jtdsp16_docache #(.DW(16), .AW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .do_start   (do_start),
    .do_data    (do_data),
    .rom_dout   (rom_dout),
    .inst_adv   (inst_adv),
    .cache_dout (cache_dout),
    .up_xcache  (up_xcache),
    .pc_hold    (pc_hold),
    .no_int     (no_int),
    .loop_busy  (loop_busy),
    .iter_left  (iter_left),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_busy = 1'b0;
  bit          m_redo = 1'b0;
  int          m_ni = 0;
  int          m_k = 0;
  int          m_cons = 0;
  int          m_stored_ni = 0;
  bit          m_fault = 1'b0;
  logic [15:0] m_cache [15];

  function automatic bit model_legal(input logic [10:0] dd);
    int ni_r = int'(dd[10:7]);
    int k_r  = int'(dd[6:0]);
    return (k_r >= 2) && (ni_r != 0 || m_stored_ni != 0);
  endfunction

  task automatic model_step(input logic c, input logic r, input logic ds,
                            input logic [10:0] dd, input logic [15:0] rw,
                            input logic adv);
    int ni_r = int'(dd[10:7]);
    int k_r  = int'(dd[6:0]);
    if (!r) begin
      m_busy = 1'b0; m_stored_ni = 0; m_fault = 1'b0;
      return;
    end
    if (!c) return;
    if (ds && !m_busy) begin
      if (model_legal(dd)) begin
        m_busy = 1'b1;
        m_redo = (ni_r == 0);
        if (ni_r != 0) m_stored_ni = ni_r;
        m_ni = m_stored_ni;
        m_k = k_r;
        m_cons = 0;
      end else begin
        m_fault = 1'b1;
      end
      return;
    end
    if (ds) m_fault = 1'b1;
    if (m_busy && adv) begin
      if (!m_redo && m_cons < m_ni) m_cache[m_cons] = rw;
      m_cons++;
      if (m_cons == m_ni * m_k) m_busy = 1'b0;
    end
  endtask

  task automatic check_outputs();
    bit          e_up;
    logic [15:0] e_dout;
    int          e_iter;
    bit          e_fault;
    e_up   = m_busy && (m_redo || m_cons >= m_ni);
    e_dout = e_up ? m_cache[m_cons % m_ni] : 16'h0;
    e_iter = m_busy ? (m_k - m_cons / m_ni) : 0;
`ifdef JTDSP16_DOCACHE_FAULT_EN
    e_fault = m_fault;
`else
    e_fault = 1'b0;
`endif
    check("loop_busy",  32'(loop_busy),  32'(m_busy));
    check("up_xcache",  32'(up_xcache),  32'(e_up));
    check("pc_hold",    32'(pc_hold),    32'(e_up));
    check("iter_left",  32'(iter_left),  32'(e_iter));
    check("cache_dout", 32'(cache_dout), 32'(e_dout));
    check("fault",      32'(fault),      32'(e_fault));
  endtask

  // One clock: drive inputs (clk low), check no_int, step model on the rising
  // edge, check registered outputs on the following falling edge.
  task automatic cycle(input logic c, input logic r, input logic ds,
                       input logic [10:0] dd, input logic [15:0] rw,
                       input logic adv);
    cen = c; rst = r; do_start = ds; do_data = dd; rom_dout = rw; inst_adv = adv;
    #1;
    if (r) check("no_int", 32'(no_int), 32'(m_busy || (ds && model_legal(dd))));
    @(posedge clk);
    model_step(c, r, ds, dd, rw, adv);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic slot(input logic ds, input logic [10:0] dd,
                      input logic [15:0] rw, input logic adv);
    cycle(1'b1, 1'b1, ds, dd, rw, adv);
  endtask

  function automatic logic [10:0] mk(input int ni, input int k);
    return {4'(ni), 7'(k)};
  endfunction

  logic [15:0] wtab [3] = '{16'h1111, 16'h2222, 16'h3333};

  initial begin
    int cons;
    int up_cnt;
    logic adv;

    // reset regardless of cen
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    check("reset_idle", 32'({loop_busy, up_xcache, pc_hold, no_int, iter_left}), 32'h0);

    // illegal: redo after reset, do K=1
    slot(1'b1, mk(0, 2), 16'h0, 1'b0);
    slot(1'b0, '0, 16'h0, 1'b0);
    slot(1'b1, mk(3, 1), 16'h0, 1'b1);
    slot(1'b0, '0, 16'h0, 1'b0);

    // do NI=3 K=4, no stalls
    slot(1'b1, mk(3, 4), 16'hdead, 1'b0);
    cons = 0;
    for (int s = 0; s < 12; s++) begin
      slot(1'b0, '0, (cons < 3) ? wtab[cons] : 16'hbeef, 1'b1);
      cons++;
    end
    slot(1'b0, '0, 16'h0, 1'b1);

    // same loop, stall on 2nd fill slot and 5th replay slot
    slot(1'b1, mk(3, 4), 16'hdead, 1'b0);
    cons = 0;
    for (int s = 0; s < 14; s++) begin
      adv = !(s == 1 || s == 8);
      slot(1'b0, '0, (adv && cons < 3) ? wtab[cons] : 16'hdead, adv);
      if (adv) cons++;
    end
    check("stall_done", 32'(loop_busy), 32'h0);

    // redo K=2: six words from cache
    slot(1'b1, mk(0, 2), 16'hdead, 1'b0);
    for (int s = 0; s < 6; s++) slot(1'b0, '0, 16'hdead, 1'b1);

    // nested do during FILL
    slot(1'b1, mk(2, 3), 16'h0, 1'b0);
    slot(1'b0, '0, 16'h4444, 1'b1);
    slot(1'b1, mk(5, 9), 16'h5555, 1'b1);
    for (int s = 0; s < 5; s++) slot(1'b0, '0, 16'h0, 1'b1);

    // reset during REPLAY with iter_left=3, then redo is illegal
    slot(1'b1, mk(2, 5), 16'h0, 1'b0);
    for (int s = 0; s < 4; s++) slot(1'b0, '0, 16'h6000 + 16'(s), 1'b1);
    check("pre_reset_iter", 32'(iter_left), 32'd3);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    check("mid_reset_idle", 32'({loop_busy, up_xcache, pc_hold, iter_left, cache_dout}), 32'h0);
    slot(1'b1, mk(0, 2), 16'h0, 1'b0);
    slot(1'b0, '0, 16'h0, 1'b1);

    // boundary NI=15 K=127
    slot(1'b1, mk(15, 127), 16'h0, 1'b0);
    up_cnt = 0;
    for (int s = 0; s < 15 + 1890; s++) begin
      slot(1'b0, '0, 16'($urandom), 1'b1);
      if (up_xcache === 1'b1) up_cnt++;
    end
    check("boundary_replay_slots", 32'(up_cnt), 32'd1890);
    check("boundary_exit", 32'({loop_busy, iter_left}), 32'h0);

    // randomized traffic
    for (int s = 0; s < 3000; s++) begin
      logic r, ds;
      r  = ($urandom_range(0, 299) != 0);
      ds = r && ($urandom_range(0, 19) == 0);
      cycle(($urandom_range(0, 4) != 0), r, ds,
            mk($urandom_range(0, 15), $urandom_range(0, 6)),
            16'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
